// File: rtl/brick_update_sched_if.sv
// Request, RAM and plotter signals of the brick update scheduler.
// The slave modport is the scheduler; the master modport is everything around it.
interface brick_update_sched_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              load_req;
  logic [ADDR_W-1:0] load_addr;
  logic [1:0]        load_health;
  logic              load_gnt;
  logic              hit_req;
  logic [ADDR_W-1:0] hit_addr;
  logic              hit_gnt;
  logic              hit_done;
  logic              hit_miss;
  logic              score_inc;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_wdata;
  logic              mem_we;
  logic [1:0]        mem_rdata;
  logic              draw_start;
  logic [ADDR_W-1:0] draw_addr;
  logic [1:0]        draw_health;
  logic              draw_done;
  logic              busy;

  modport slave (
    input  load_req, load_addr, load_health, hit_req, hit_addr, mem_rdata, draw_done,
    output load_gnt, hit_gnt, hit_done, hit_miss, score_inc, mem_addr, mem_wdata, mem_we,
           draw_start, draw_addr, draw_health, busy
  );

  modport master (
    output load_req, load_addr, load_health, hit_req, hit_addr, mem_rdata, draw_done,
    input  load_gnt, hit_gnt, hit_done, hit_miss, score_inc, mem_addr, mem_wdata, mem_we,
           draw_start, draw_addr, draw_health, busy
  );
endinterface

// File: rtl/brick_update_sched.sv
// Serialises loader writes and collision read-modify-write decrements on the brick RAM,
// following every health change with one brick redraw before accepting new work.
module brick_update_sched #(
  parameter int unsigned BRICK_COUNT = 36,
  parameter int unsigned ADDR_W      = 10
) (
  input logic                  clk,
  input logic                  resetn,
  brick_update_sched_if.slave  bus
);

  localparam logic [ADDR_W-1:0] CountA = ADDR_W'(BRICK_COUNT);

  typedef enum logic [2:0] {
    StIdle,
    StLoadWr,
    StHitRd,
    StHitWait,
    StHitWr,
    StDraw,
    StDrawWait
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        health_q;
  logic              is_hit_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [1:0]        mem_wdata_q;
  logic              mem_we_q;
  logic              draw_start_q;
  logic [ADDR_W-1:0] draw_addr_q;
  logic [1:0]        draw_health_q;
  logic              score_q;
  logic              done_q;
  logic              miss_q;

  logic idle;
  assign idle = (state_q == StIdle);

  // Grants are decided in the IDLE cycle itself so the write lands one cycle later.
  assign bus.load_gnt    = resetn & idle & bus.load_req;
  assign bus.hit_gnt     = resetn & idle & bus.hit_req & ~bus.load_req;
  assign bus.hit_done    = done_q |
                           (resetn & (state_q == StDrawWait) & is_hit_q & bus.draw_done);
  assign bus.hit_miss    = miss_q;
  assign bus.score_inc   = score_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.draw_start  = draw_start_q;
  assign bus.draw_addr   = draw_addr_q;
  assign bus.draw_health = draw_health_q;
  assign bus.busy        = ~idle;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      health_q      <= '0;
      is_hit_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      draw_start_q  <= 1'b0;
      draw_addr_q   <= '0;
      draw_health_q <= '0;
      score_q       <= 1'b0;
      done_q        <= 1'b0;
      miss_q        <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      draw_start_q <= 1'b0;
      score_q      <= 1'b0;
      done_q       <= 1'b0;
      miss_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.load_req) begin
            addr_q   <= bus.load_addr;
            health_q <= bus.load_health;
            is_hit_q <= 1'b0;
            if (bus.load_addr < CountA) begin
              state_q     <= StLoadWr;
              mem_addr_q  <= bus.load_addr;
              mem_wdata_q <= bus.load_health;
              mem_we_q    <= 1'b1;
            end
          end else if (bus.hit_req) begin
            addr_q   <= bus.hit_addr;
            is_hit_q <= 1'b1;
            if (bus.hit_addr < CountA) begin
              state_q    <= StHitRd;
              mem_addr_q <= bus.hit_addr;
            end else begin
              done_q <= 1'b1;
              miss_q <= 1'b1;
            end
          end
        end
        StLoadWr: begin
          state_q       <= StDraw;
          draw_start_q  <= 1'b1;
          draw_addr_q   <= addr_q;
          draw_health_q <= health_q;
        end
        StHitRd: state_q <= StHitWait;
        StHitWait: begin
          // RAM data is valid now; decide the write for the following cycle.
          state_q  <= StHitWr;
          health_q <= bus.mem_rdata;
          if (bus.mem_rdata == 2'd0) begin
            done_q <= 1'b1;
            miss_q <= 1'b1;
          end else begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= bus.mem_rdata - 2'd1;
            score_q     <= (bus.mem_rdata == 2'd1);
          end
        end
        StHitWr: begin
          if (health_q == 2'd0) begin
            state_q <= StIdle;
          end else begin
            state_q       <= StDraw;
            draw_start_q  <= 1'b1;
            draw_addr_q   <= addr_q;
            draw_health_q <= health_q - 2'd1;
          end
        end
        StDraw: state_q <= StDrawWait;
        StDrawWait: begin
          if (bus.draw_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_brick_update_sched.sv
// Directed bench for brick_update_sched with a synchronous RAM model; the plotter
// completion is driven by hand at the expected cycle.
module tb_brick_update_sched;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  int   draw_cnt = 0;
  int   we0;
  int   dr0;

  logic [1:0] ram [0:63];

  brick_update_sched_if #(.ADDR_W(10)) b ();

  brick_update_sched #(
    .BRICK_COUNT(36),
    .ADDR_W     (10)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b.mem_we) begin
      ram[b.mem_addr[5:0]] <= b.mem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (b.draw_start) draw_cnt <= draw_cnt + 1;
    b.mem_rdata <= ram[b.mem_addr[5:0]];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full load including redraw; caller guarantees the scheduler is idle.
  task automatic do_load(input logic [9:0] a, input logic [1:0] h);
    b.load_req = 1'b1;
    b.load_addr = a;
    b.load_health = h;
    tick();
    b.load_req = 1'b0;
    tick();
    tick();
    b.draw_done = 1'b1;
    tick();
    b.draw_done = 1'b0;
  endtask

  initial begin
    #100000;
    n_fail++;
    $error("FAIL timeout: bench did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    b.load_req = 1'b0;
    b.load_addr = '0;
    b.load_health = '0;
    b.hit_req = 1'b0;
    b.hit_addr = '0;
    b.draw_done = 1'b0;
    repeat (3) tick();
    check("reset_outs", {b.load_gnt, b.hit_gnt, b.hit_done, b.hit_miss, b.score_inc,
                         b.mem_addr, b.mem_wdata, b.mem_we, b.draw_start, b.draw_addr,
                         b.draw_health, b.busy}, 64'd0);
    resetn = 1'b1;

    // Load addr 5 health 3
    b.load_req = 1'b1; b.load_addr = 10'd5; b.load_health = 2'd3;
    #1;
    check("load_gnt", b.load_gnt, 1'b1);
    check("load_idle_busy", b.busy, 1'b0);
    tick();
    b.load_req = 1'b0;
    check("load_we", b.mem_we, 1'b1);
    check("load_addr", b.mem_addr, 10'd5);
    check("load_wdata", b.mem_wdata, 2'd3);
    check("load_gnt_pulse", b.load_gnt, 1'b0);
    tick();
    check("load_draw_start", b.draw_start, 1'b1);
    check("load_draw_addr", b.draw_addr, 10'd5);
    check("load_draw_health", b.draw_health, 2'd3);
    check("load_we_once", b.mem_we, 1'b0);
    tick();
    check("load_draw_pulse", b.draw_start, 1'b0);
    check("load_wait_busy", b.busy, 1'b1);
    b.draw_done = 1'b1;
    tick();
    b.draw_done = 1'b0;
    check("load_end_busy", b.busy, 1'b0);
    check("load_ram5", ram[5], 2'd3);

    // Hit decrement 2 -> 1
    do_load(10'd2, 2'd2);
    b.hit_req = 1'b1; b.hit_addr = 10'd2;
    #1;
    check("hit_gnt", b.hit_gnt, 1'b1);
    tick();
    b.hit_req = 1'b0;
    check("hit_rd_addr", b.mem_addr, 10'd2);
    check("hit_rd_we", b.mem_we, 1'b0);
    tick();
    check("hit_wait_we", b.mem_we, 1'b0);
    tick();
    check("hit_wr_we", b.mem_we, 1'b1);
    check("hit_wr_data", b.mem_wdata, 2'd1);
    check("hit_no_score", b.score_inc, 1'b0);
    tick();
    check("hit_draw_start", b.draw_start, 1'b1);
    check("hit_draw_health", b.draw_health, 2'd1);
    check("hit_draw_addr", b.draw_addr, 10'd2);
    tick();
    check("hit_done_early", b.hit_done, 1'b0);
    b.draw_done = 1'b1;
    #1;
    check("hit_done", b.hit_done, 1'b1);
    check("hit_done_miss", b.hit_miss, 1'b0);
    tick();
    b.draw_done = 1'b0;
    check("hit_done_pulse", b.hit_done, 1'b0);
    check("hit_end_busy", b.busy, 1'b0);

    // Kill brick 3 (1 -> 0), then hit it again while dead
    do_load(10'd3, 2'd1);
    b.hit_req = 1'b1; b.hit_addr = 10'd3;
    tick();
    b.hit_req = 1'b0;
    tick();
    tick();
    check("kill_we", b.mem_we, 1'b1);
    check("kill_wdata", b.mem_wdata, 2'd0);
    check("kill_score", b.score_inc, 1'b1);
    tick();
    check("kill_draw_health", b.draw_health, 2'd0);
    check("kill_score_pulse", b.score_inc, 1'b0);
    tick();
    b.draw_done = 1'b1;
    tick();
    b.draw_done = 1'b0;
    we0 = we_cnt;
    dr0 = draw_cnt;
    b.hit_req = 1'b1;
    tick();
    b.hit_req = 1'b0;
    tick();
    tick();
    check("dead_we", b.mem_we, 1'b0);
    check("dead_done", b.hit_done, 1'b1);
    check("dead_miss", b.hit_miss, 1'b1);
    check("dead_score", b.score_inc, 1'b0);
    tick();
    check("dead_idle", b.busy, 1'b0);
    check("dead_no_draw", b.draw_start, 1'b0);
    tick();
    check("dead_draw_cnt", draw_cnt, dr0);
    check("dead_we_cnt", we_cnt, we0);

    // Simultaneous load and hit on addr 7: load wins, hit sees the loaded value
    b.load_req = 1'b1; b.load_addr = 10'd7; b.load_health = 2'd2;
    b.hit_req = 1'b1; b.hit_addr = 10'd7;
    #1;
    check("prio_load_gnt", b.load_gnt, 1'b1);
    check("prio_hit_held", b.hit_gnt, 1'b0);
    tick();
    b.load_req = 1'b0;
    check("prio_hit_busy", b.hit_gnt, 1'b0);
    tick();
    tick();
    check("prio_hit_wait", b.hit_gnt, 1'b0);
    b.draw_done = 1'b1;
    tick();
    b.draw_done = 1'b0;
    check("prio_hit_gnt", b.hit_gnt, 1'b1);
    tick();
    b.hit_req = 1'b0;
    tick();
    tick();
    check("prio_wr_we", b.mem_we, 1'b1);
    check("prio_wr_data", b.mem_wdata, 2'd1);
    tick();
    tick();
    b.draw_done = 1'b1;
    tick();
    b.draw_done = 1'b0;
    check("prio_ram7", ram[7], 2'd1);

    // Out-of-range hit and load, spurious draw_done
    we0 = we_cnt;
    dr0 = draw_cnt;
    b.hit_req = 1'b1; b.hit_addr = 10'd36;
    #1;
    check("oor_hit_gnt", b.hit_gnt, 1'b1);
    tick();
    b.hit_req = 1'b0;
    check("oor_hit_done", b.hit_done, 1'b1);
    check("oor_hit_miss", b.hit_miss, 1'b1);
    check("oor_hit_busy", b.busy, 1'b0);
    tick();
    check("oor_hit_pulse", b.hit_done, 1'b0);
    b.load_req = 1'b1; b.load_addr = 10'd40; b.load_health = 2'd1;
    #1;
    check("oor_load_gnt", b.load_gnt, 1'b1);
    tick();
    b.load_req = 1'b0;
    check("oor_load_we", b.mem_we, 1'b0);
    check("oor_load_busy", b.busy, 1'b0);
    tick();
    check("oor_load_draw", b.draw_start, 1'b0);
    b.draw_done = 1'b1;
    #1;
    check("spur_done", b.hit_done, 1'b0);
    tick();
    b.draw_done = 1'b0;
    check("spur_busy", b.busy, 1'b0);
    tick();
    check("oor_we_cnt", we_cnt, we0);
    check("oor_draw_cnt", draw_cnt, dr0);

    // Reset during HIT_WAIT on brick 5
    we0 = we_cnt;
    b.hit_req = 1'b1; b.hit_addr = 10'd5;
    tick();
    b.hit_req = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    check("rst_mid_outs", {b.load_gnt, b.hit_gnt, b.hit_done, b.hit_miss, b.score_inc,
                           b.mem_addr, b.mem_wdata, b.mem_we, b.draw_start, b.draw_addr,
                           b.draw_health, b.busy}, 64'd0);
    resetn = 1'b1;
    tick();
    check("rst_mid_done", b.hit_done, 1'b0);
    check("rst_mid_we", b.mem_we, 1'b0);
    tick();
    check("rst_mid_we_cnt", we_cnt, we0);
    check("rst_mid_ram5", ram[5], 2'd3);
    b.load_req = 1'b1; b.load_addr = 10'd9; b.load_health = 2'd2;
    #1;
    check("post_rst_gnt", b.load_gnt, 1'b1);
    tick();
    b.load_req = 1'b0;
    check("post_rst_we", b.mem_we, 1'b1);
    check("post_rst_addr", b.mem_addr, 10'd9);
    tick();
    check("post_rst_draw", b.draw_start, 1'b1);
    tick();
    b.draw_done = 1'b1;
    tick();
    b.draw_done = 1'b0;
    check("post_rst_busy", b.busy, 1'b0);
    check("post_rst_ram9", ram[9], 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/brick_update_sched.md
Name: brick_update_sched

Overview:
- Sequences all accesses to the single-port brick health RAM and to the brick plotter.
- Two requesters share these resources: the level loader, which writes initial health, and the collision logic, which performs a read-modify-write decrement when the ball hits a brick.
- After every health change it issues one brick redraw and waits for the plotter to finish, so the RAM and the screen never disagree.
- Sits between load_data and the collision unit on one side, and the brick RAM and VGA brick drawer on the other.

Parameters:
- BRICK_COUNT, 36: number of valid brick addresses (0..BRICK_COUNT-1).
- ADDR_W, 10: brick address width.

Ports:
- clk          in   1       system clock
- resetn       in   1       synchronous, active-low reset
- load_req     in   1       loader requests a write; held until load_gnt
- load_addr    in   ADDR_W  brick address to initialise
- load_health  in   2       initial health (0..3)
- load_gnt     out  1       1-cycle pulse; load inputs captured this cycle
- hit_req      in   1       collision requests a decrement; held until hit_gnt
- hit_addr     in   ADDR_W  brick that was hit
- hit_gnt      out  1       1-cycle pulse; hit_addr captured this cycle
- hit_done     out  1       1-cycle pulse; hit operation fully finished
- hit_miss     out  1       qualifies hit_done: brick already dead or address out of range
- score_inc    out  1       1-cycle pulse when a brick goes from health 1 to 0
- mem_addr     out  ADDR_W  RAM address
- mem_wdata    out  2       RAM write data
- mem_we       out  1       RAM write enable
- mem_rdata    in   2       RAM read data; synchronous RAM, 1-cycle latency
- draw_start   out  1       1-cycle pulse to the plotter
- draw_addr    out  ADDR_W  brick to redraw; held from draw_start until draw_done
- draw_health  out  2       health selecting the colour; 0 = erase/background
- draw_done    in   1       plotter completion pulse
- busy         out  1       high in every state except IDLE

Behaviour:
- Reset (clk edge with resetn=0):
  - FSM goes to IDLE.
  - All outputs are 0, including mem_addr, draw_addr, and the latched addr/health registers.
  - An in-flight operation is abandoned: no write, no done pulse, no score pulse.
- States: IDLE, LOAD_WR, HIT_RD, HIT_WAIT, HIT_WR, DRAW, DRAW_WAIT.
- Arbitration, evaluated only in IDLE:
  - load_req has fixed priority over hit_req.
  - A grant is issued only from IDLE; requests seen in any other state wait.
- Load path:
  - IDLE with load_req: pulse load_gnt, latch addr and health, go to LOAD_WR.
  - If the latched addr >= BRICK_COUNT, return to IDLE instead: no write, no draw.
  - LOAD_WR: mem_addr=addr, mem_wdata=health, mem_we=1 for exactly one cycle, then go to DRAW with draw_health=health.
- Hit path:
  - IDLE with hit_req and no load_req: pulse hit_gnt, latch addr.
  - If addr >= BRICK_COUNT: go to IDLE; hit_done=1 and hit_miss=1 on the next cycle; no RAM access.
  - HIT_RD: mem_addr=addr, mem_we=0.
  - HIT_WAIT: mem_addr held; capture mem_rdata at the end of the cycle.
  - HIT_WR, captured health h=0: no write; pulse hit_done with hit_miss=1; go to IDLE; no redraw.
  - HIT_WR, h>0: mem_we=1 and mem_wdata=h-1 for one cycle. The decrement never wraps.
  - If h=1, score_inc pulses in the same cycle.
  - Then go to DRAW with draw_health=h-1.
- DRAW: draw_start=1 for one cycle; draw_addr and draw_health become valid this cycle. Then go to DRAW_WAIT.
- DRAW_WAIT:
  - Outputs are held until draw_done=1, then go to IDLE.
  - If the operation was a hit, hit_done pulses (hit_miss=0) in the cycle draw_done is seen.
  - A draw_done seen in any other state is ignored.
- Latency, no stall:
  - Load: gnt to write = 1 cycle.
  - Hit: gnt to write = 3 cycles (gnt, RD, WAIT, WR); draw_start is 1 cycle after the write.
- Simultaneous events:
  - A request held through a busy period is granted on the first IDLE cycle after completion.
  - Back-to-back hits on the same address each observe the previous write, because the RAM write lands before the next grant.
- Single outstanding operation only. Requesters must not change addr/health between req and gnt.

Test Plan:
- Load: reset, then load_req addr=5 health=3 → load_gnt pulse; next cycle mem_we=1, mem_addr=5, mem_wdata=3; then draw_start with draw_addr=5, draw_health=3; after draw_done, busy=0.
- Hit decrement: RAM[2]=2, hit_req addr=2 → hit_gnt; read at cycle +1; write 1 at cycle +3; draw_health=1; hit_done with hit_miss=0 on draw_done; score_inc stays 0.
- Kill and dead brick: RAM[3]=1; hit addr=3 → write 0, score_inc pulse, draw_health=0. Repeat hit addr=3 → no mem_we, hit_done with hit_miss=1, no draw_start.
- Priority: load_req and hit_req asserted in the same IDLE cycle → load granted first. hit_gnt follows on the first IDLE cycle after the load's draw_done, and the hit reads the newly loaded value.
- Range/ignore: hit addr=36 → hit_done with hit_miss=1 one cycle after gnt, mem never accessed. Load addr=40 → gnt only, no write. Spurious draw_done while IDLE → no effect.
- Reset mid-op: resetn=0 during HIT_WAIT, then release → all outputs 0, no write to RAM, no hit_done; a new load completes normally.
